// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: config register map,
// CTRL/STATUS bit positions, FSM state codes and the CTRL register layout.
package led_seq_pkg;

  localparam int unsigned CFG_AW   = 3;
  localparam int unsigned DAT_W    = 8;
  localparam int unsigned PER_W    = 16;
  localparam int unsigned NPAT_MAX = 4;

  // Config register map
  localparam logic [2:0] ADR_CTRL   = 3'd0;
  localparam logic [2:0] ADR_PER_LO = 3'd1;
  localparam logic [2:0] ADR_PER_HI = 3'd2;
  localparam logic [2:0] ADR_STATUS = 3'd3;
  localparam logic [2:0] ADR_PAT0   = 3'd4;

  // CTRL / STATUS bit positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_ONESHOT  = 1;
  localparam int unsigned CTRL_NPAT_LSB = 2;
  localparam int unsigned CTRL_BUSY     = 7;
  localparam int unsigned STAT_ERR      = 0;
  localparam int unsigned STAT_IDX_LSB  = 1;

  // FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  // CTRL storage, bit 0 = EN
  typedef struct packed {
    logic [1:0] npat_m1;
    logic       oneshot;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/led_seq_if.sv
// Classic Wishbone bus bundle. The sequencer uses one instance (AW=3) as its
// config slave port and one (AW=32) as the master port towards the LED slave.
//   adr/dat_w/we/cyc/stb/cti/bte : master -> slave
//   dat_r/ack/err/rty            : slave -> master
interface led_seq_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (output adr, dat_w, we, cyc, stb, cti, bte,
                  input  ack, err, rty);
  modport slave  (input  adr, dat_w, we, cyc, stb,
                  output dat_r, ack, err, rty);
endinterface

// File: rtl/led_seq_regs.sv
// Config slave of the LED sequencer: address decode, single-cycle ack and
// the register file (CTRL, PERIOD, STATUS.ERR, PAT0-3).
//   clk, rst_n    : clock, async active-low reset
//   wbs           : Wishbone config slave port
//   busy, idx     : live FSM status for CTRL/STATUS reads
//   err_set_c     : FSM sets sticky ERR (wins over a software clear)
//   en_clr_c      : FSM clears CTRL.EN
//   ctrl, period, pat : register contents used by the FSM
module led_seq_regs
  import led_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  led_seq_if.slave        wbs,
  input  logic            busy,
  input  logic [1:0]      idx,
  input  logic            err_set_c,
  input  logic            en_clr_c,
  output ctrl_t           ctrl,
  output logic [15:0]     period,
  output logic [3:0][7:0] pat
);

  logic            ack_q, ack_d;
  logic [7:0]      rdat_q, rdat_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [7:0]      per_lo_q, per_lo_d;
  logic [7:0]      per_hi_q, per_hi_d;
  logic            err_q, err_d;
  logic [3:0][7:0] pat_q, pat_d;
  logic            req_c;
  logic [7:0]      rmux_c;

  // Decode, read mux and register updates; all writes commit on the ack edge
  always_comb begin
    ack_d    = 1'b0;
    rdat_d   = rdat_q;
    ctrl_d   = ctrl_q;
    per_lo_d = per_lo_q;
    per_hi_d = per_hi_q;
    err_d    = err_q;
    pat_d    = pat_q;
    rmux_c   = '0;

    // ack_q masks the request so ack can never be high two cycles running
    req_c = wbs.cyc & wbs.stb & ~ack_q;

    case (wbs.adr)
      ADR_CTRL: begin
        rmux_c[3:0]       = ctrl_q;
        rmux_c[CTRL_BUSY] = busy;
      end
      ADR_PER_LO: rmux_c = per_lo_q;
      ADR_PER_HI: rmux_c = per_hi_q;
      ADR_STATUS: begin
        rmux_c[STAT_ERR]          = err_q;
        rmux_c[STAT_IDX_LSB +: 2] = idx;
      end
      default:    rmux_c = pat_q[wbs.adr[1:0]];
    endcase

    if (req_c) begin
      ack_d  = 1'b1;
      rdat_d = rmux_c;
      if (wbs.we) begin
        case (wbs.adr)
          ADR_CTRL:   ctrl_d   = ctrl_t'(wbs.dat_w[3:0]);
          ADR_PER_LO: per_lo_d = wbs.dat_w;
          ADR_PER_HI: per_hi_d = wbs.dat_w;
          ADR_STATUS: if (wbs.dat_w[STAT_ERR]) err_d = 1'b0;
          default:    pat_d[wbs.adr[1:0]] = wbs.dat_w;
        endcase
      end
    end

    if (en_clr_c)  ctrl_d.en = 1'b0;
    if (err_set_c) err_d     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      ctrl_q   <= '0;
      per_lo_q <= '0;
      per_hi_q <= '0;
      err_q    <= 1'b0;
      pat_q    <= '0;
    end else begin
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      ctrl_q   <= ctrl_d;
      per_lo_q <= per_lo_d;
      per_hi_q <= per_hi_d;
      err_q    <= err_d;
      pat_q    <= pat_d;
    end
  end

  assign wbs.ack   = ack_q;
  assign wbs.dat_r = rdat_q;
  assign wbs.err   = 1'b0;
  assign wbs.rty   = 1'b0;
  assign ctrl      = ctrl_q;
  assign period    = {per_hi_q, per_lo_q};
  assign pat       = pat_q;

endmodule

// File: rtl/led_seq.sv
// LED pattern sequencer: cycles through up to four byte patterns, writing
// each to an LED slave over a Wishbone master port, with a programmable
// period between writes, one-shot mode and a transfer timeout.
//   wb_clk, wb_rst_n : clock, async active-low reset
//   wbs              : config slave port (3-bit address, 8-bit data)
//   wbm              : master port towards the LED slave (32-bit address)
module led_seq
  import led_seq_pkg::*;
#(
  parameter logic [31:0] LED_ADR = 32'h9100_0000,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic      wb_clk,
  input  logic      wb_rst_n,
  led_seq_if.slave  wbs,
  led_seq_if.master wbm
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             cyc_q, cyc_d;
  logic [7:0]       dat_q, dat_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       idx_nxt_c;
  logic             en_clr_c;
  logic             err_set_c;
  ctrl_t            ctrl;
  logic [15:0]      period;
  logic [3:0][7:0]  pat;

  led_seq_regs u_regs (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .wbs       (wbs),
    .busy      (state_q != ST_IDLE),
    .idx       (idx_q),
    .err_set_c (err_set_c),
    .en_clr_c  (en_clr_c),
    .ctrl      (ctrl),
    .period    (period),
    .pat       (pat)
  );

  // Sequencer FSM: IDLE -> XFER -> COUNT -> XFER ...
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cyc_d     = cyc_q;
    dat_d     = dat_q;
    tmo_d     = tmo_q;
    en_clr_c  = 1'b0;
    err_set_c = 1'b0;
    // >= so a shrunken NPAT wraps on the next advance
    idx_nxt_c = (idx_q >= ctrl.npat_m1) ? 2'd0 : idx_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_d = ST_XFER;
          cnt_d   = period;
          cyc_d   = 1'b1;
          dat_d   = pat[idx_q];
          tmo_d   = '0;
        end
      end
      ST_COUNT: begin
        if (!ctrl.en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_XFER;
          cyc_d   = 1'b1;
          dat_d   = pat[idx_q];
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_XFER: begin
        if (wbm.ack) begin
          cyc_d = 1'b0;
          idx_d = idx_nxt_c;
          cnt_d = period;
          if (ctrl.oneshot && (idx_nxt_c == 2'd0)) begin
            en_clr_c = 1'b1;
            state_d  = ST_IDLE;
          end else if (!ctrl.en) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COUNT;
          end
        end else if (wbm.err || wbm.rty || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          cyc_d     = 1'b0;
          err_set_c = 1'b1;
          en_clr_c  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= 1'b0;
      dat_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wbm.adr   = LED_ADR;
  assign wbm.dat_w = dat_q;
  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.we    = cyc_q;
  assign wbm.cti   = 3'b000;
  assign wbm.bte   = 2'b00;

endmodule

// File: tb/tb_led_seq.sv
// Self-checking bench for led_seq: directed config sequences, an LED-slave
// responder, and a per-cycle model of the master bus derived from the
// schedule arithmetic (a transfer every PERIOD+3 cycles with 1-cycle acks).
module tb_led_seq;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_seq_if #(.AW(3),  .DW(8)) wbs ();
  led_seq_if #(.AW(32), .DW(8)) wbm ();

  led_seq #(.LED_ADR(32'h9100_0000), .TIMEOUT(15)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .wbs      (wbs),
    .wbm      (wbm)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int last_ack_cyc = 0;

  // Schedule model parameters
  bit         model_on = 1'b0;
  int         t0, per, npat, nmax;
  logic [7:0] mpat [4];
  int         rel, k, ph;
  logic       ec;

  // LED slave responder: 0 = ack, 1 = err, 2 = never respond
  int resp_kind = 0;
  int resp_lat  = 1;
  int wait_cnt  = 0;
  logic [7:0] led_log [$];
  int         ack_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Responder and per-cycle compare
  initial begin
    wbm.ack = 1'b0; wbm.err = 1'b0; wbm.rty = 1'b0; wbm.dat_r = '0;
    forever begin
      @(posedge clk);
      cyc_n++;
      #1;
      if (wbm.cyc === 1'b1 && wbm.stb === 1'b1) wait_cnt++;
      else wait_cnt = 0;
      wbm.ack = (resp_kind == 0) && (wait_cnt == resp_lat + 1);
      wbm.err = (resp_kind == 1) && (wait_cnt == resp_lat + 1);
      if (wbm.ack && wbm.cyc === 1'b1) begin
        led_log.push_back(wbm.dat_w);
        ack_log.push_back(cyc_n);
      end
      #1;
      if (model_on) begin
        rel = cyc_n - t0;
        ec  = 1'b0;
        k   = 0;
        if (rel >= 0) begin
          k  = rel / (per + 3);
          ph = rel % (per + 3);
          ec = (ph < 2) && (nmax < 0 || k < nmax);
        end
        chk("model_cyc", 32'(wbm.cyc), 32'(ec));
        chk("model_stb", 32'(wbm.stb), 32'(ec));
        chk("model_we",  32'(wbm.we),  32'(ec));
        if (ec) begin
          chk("model_dat", 32'(wbm.dat_w), 32'(mpat[k % npat]));
          chk("model_adr", wbm.adr, 32'h9100_0000);
        end
      end
    end
  end

  task automatic cfg_xfer(input logic we, input logic [2:0] adr, input logic [7:0] wd,
                          output logic [7:0] rd);
    int n;
    @(posedge clk); #1;
    wbs.adr = adr; wbs.dat_w = wd; wbs.we = we; wbs.cyc = 1'b1; wbs.stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (wbs.ack !== 1'b1 && n < 10);
    chk("cfg_ack", 32'(wbs.ack), 32'd1);
    rd = wbs.dat_r;
    last_ack_cyc = cyc_n;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [7:0] d);
    logic [7:0] x;
    cfg_xfer(1'b1, adr, d, x);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] adr, input logic [7:0] exp);
    logic [7:0] x;
    cfg_xfer(1'b0, adr, 8'h00, x);
    chk(name, 32'(x), 32'(exp));
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_led_cyc(input string name, input int budget);
    int n;
    n = 0;
    while (wbm.cyc !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(wbm.cyc), 32'd1);
  endtask

  task automatic wait_log(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (led_log.size() < cnt && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(led_log.size() >= cnt), 32'd1);
  endtask

  task automatic do_reset();
    model_on = 1'b0; resp_kind = 0; resp_lat = 1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    led_log.delete(); ack_log.delete();
  endtask

  initial begin
    int hi, n, sz;
    rst_n = 1'b0;
    wbs.adr = '0; wbs.dat_w = '0; wbs.we = 1'b0; wbs.cyc = 1'b0; wbs.stb = 1'b0;
    wbs.cti = '0; wbs.bte = '0;
    #12;
    chk("rst_cyc",  32'(wbm.cyc), 32'd0);
    chk("rst_stb",  32'(wbm.stb), 32'd0);
    chk("rst_we",   32'(wbm.we),  32'd0);
    chk("rst_dat",  32'(wbm.dat_w), 32'd0);
    chk("rst_ack",  32'(wbs.ack), 32'd0);
    chk("tie_err",  32'(wbs.err), 32'd0);
    chk("tie_rty",  32'(wbs.rty), 32'd0);
    chk("led_adr",  wbm.adr, 32'h9100_0000);
    chk("cti",      32'(wbm.cti), 32'd0);
    chk("bte",      32'(wbm.bte), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d", a), 3'(a), 8'h00);

    // Back-to-back reads with cyc/stb held: ack alternates 0/1
    @(posedge clk); #1;
    wbs.adr = ADR_PER_LO; wbs.we = 1'b0; wbs.cyc = 1'b1; wbs.stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ack", 32'(wbs.ack), 32'(i % 2));
      @(posedge clk); #1;
    end
    wbs.cyc = 1'b0; wbs.stb = 1'b0;

    // Free-running, PERIOD=3, two patterns
    wr(ADR_PAT0, 8'hA5);
    wr(ADR_PAT0 + 3'd1, 8'h5A);
    wr(ADR_PER_LO, 8'd3);
    wr(ADR_PER_HI, 8'd0);
    rd_chk("per_lo_rb", ADR_PER_LO, 8'd3);
    mpat[0] = 8'hA5; mpat[1] = 8'h5A; mpat[2] = 8'h00; mpat[3] = 8'h00;
    per = 3; npat = 2; nmax = -1;
    wr(ADR_CTRL, 8'h05);
    t0 = last_ack_cyc + 1;
    model_on = 1'b1;
    wait_cyc(40);
    model_on = 1'b0;
    chk("run_log_n", 32'(led_log.size() >= 3), 32'd1);
    if (led_log.size() >= 3) begin
      chk("run_w0", 32'(led_log[0]), 32'hA5);
      chk("run_w1", 32'(led_log[1]), 32'h5A);
      chk("run_w2", 32'(led_log[2]), 32'hA5);
      chk("run_first_ack", 32'(ack_log[0] - t0), 32'd1);
      chk("run_spacing01", 32'(ack_log[1] - ack_log[0]), 32'd6);
      chk("run_spacing12", 32'(ack_log[2] - ack_log[1]), 32'd6);
    end
    rd_chk("run_busy", ADR_CTRL, 8'h85);
    wr(ADR_CTRL, 8'h00);
    wait_cyc(20);
    chk("stop_cyc", 32'(wbm.cyc), 32'd0);
    rd_chk("stop_ctrl", ADR_CTRL, 8'h00);

    // One-shot through four patterns
    do_reset();
    wr(ADR_PAT0,        8'h11);
    wr(ADR_PAT0 + 3'd1, 8'h22);
    wr(ADR_PAT0 + 3'd2, 8'h33);
    wr(ADR_PAT0 + 3'd3, 8'h44);
    mpat[0] = 8'h11; mpat[1] = 8'h22; mpat[2] = 8'h33; mpat[3] = 8'h44;
    per = 0; npat = 4; nmax = 4;
    wr(ADR_CTRL, 8'h0F);
    t0 = last_ack_cyc + 1;
    model_on = 1'b1;
    wait_cyc(30);
    model_on = 1'b0;
    chk("os_log_n", 32'(led_log.size()), 32'd4);
    if (led_log.size() == 4) begin
      chk("os_w0", 32'(led_log[0]), 32'h11);
      chk("os_w3", 32'(led_log[3]), 32'h44);
    end
    rd_chk("os_ctrl",   ADR_CTRL,   8'h0E);
    rd_chk("os_status", ADR_STATUS, 8'h00);

    // Error response mid-sequence keeps idx
    do_reset();
    wr(ADR_PAT0,        8'h66);
    wr(ADR_PAT0 + 3'd1, 8'h77);
    wr(ADR_CTRL, 8'h05);
    wait_log("err_first", 1, 50);
    resp_kind = 1;
    wait_cyc(20);
    chk("err_log_n", 32'(led_log.size()), 32'd1);
    chk("err_cyc",   32'(wbm.cyc), 32'd0);
    rd_chk("err_status", ADR_STATUS, 8'h03);
    rd_chk("err_ctrl",   ADR_CTRL,   8'h04);
    wr(ADR_STATUS, 8'h01);
    rd_chk("err_clr",    ADR_STATUS, 8'h02);

    // Timeout with a silent slave
    do_reset();
    resp_kind = 2;
    wr(ADR_PAT0, 8'h77);
    wr(ADR_CTRL, 8'h01);
    wait_led_cyc("tmo_start", 10);
    hi = 0;
    while (wbm.cyc === 1'b1 && hi < 40) begin
      hi++;
      @(posedge clk); #1;
    end
    chk("tmo_len", 32'(hi), 32'd15);
    rd_chk("tmo_status", ADR_STATUS, 8'h01);
    rd_chk("tmo_ctrl",   ADR_CTRL,   8'h00);
    wr(ADR_STATUS, 8'h01);
    rd_chk("tmo_clr",    ADR_STATUS, 8'h00);

    // Pattern rewrite during an in-flight transfer
    do_reset();
    resp_lat = 5;
    wr(ADR_PAT0,        8'h11);
    wr(ADR_PAT0 + 3'd1, 8'h22);
    wr(ADR_CTRL, 8'h05);
    wait_led_cyc("fly_start", 10);
    chk("fly_dat0", 32'(wbm.dat_w), 32'h11);
    wr(ADR_PAT0, 8'hFF);
    n = 0;
    while (wbm.cyc === 1'b1 && n < 20) begin
      chk("fly_dat", 32'(wbm.dat_w), 32'h11);
      @(posedge clk); #1;
      n++;
    end
    wait_log("fly_log", 3, 100);
    if (led_log.size() >= 3) begin
      chk("fly_w0", 32'(led_log[0]), 32'h11);
      chk("fly_w1", 32'(led_log[1]), 32'h22);
      chk("fly_w2", 32'(led_log[2]), 32'hFF);
    end

    // Reset pulse mid-transfer
    wait_led_cyc("rst_xfer_start", 30);
    sz = led_log.size();
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rstx_cyc", 32'(wbm.cyc), 32'd0);
    chk("rstx_stb", 32'(wbm.stb), 32'd0);
    chk("rstx_dat", 32'(wbm.dat_w), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rstx_reg%0d", a), 3'(a), 8'h00);
    chk("rstx_no_ack", 32'(led_log.size()), 32'(sz));
    chk("rstx_idle",   32'(wbm.cyc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule
